// File: rtl/r16_pkg.sv
// Shared types and default phase lengths for the radix-16 FFT
// sequencer, its AGU and the testbench.
package r16_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        COMP   = 3'd2,
        DRAIN  = 3'd3,
        UNLOAD = 3'd4,
        FLUSH  = 3'd5
    } r16_state_e;

    localparam int DEF_CNT_WIDTH     = 13;
    localparam int DEF_LOAD_BEATS    = 1024;
    localparam int DEF_COMP_CYCLES   = 4144;
    localparam int DEF_DRAIN_CYCLES  = 8;
    localparam int DEF_UNLOAD_CYCLES = 1026;
    localparam int DEF_OUT_LAT       = 3;

endpackage

// File: rtl/r16_fft_seq_if.sv
// Host, sample-input and AGU control signals of the FFT sequencer.
// master = host side, slave = sequencer.
interface r16_fft_seq_if;

    logic       start;
    logic       busy;
    logic       done;
    logic       start_err;
    logic       in_valid;
    logic       in_ready;
    logic       wrfd_en;
    logic       agu_en;
    logic       rc_sel;
    logic       out_valid;
    logic [2:0] phase;

    modport master (
        output start, in_valid,
        input  busy, done, start_err, in_ready, wrfd_en,
        input  agu_en, rc_sel, out_valid, phase
    );

    modport slave (
        input  start, in_valid,
        output busy, done, start_err, in_ready, wrfd_en,
        output agu_en, rc_sel, out_valid, phase
    );

endinterface

// File: rtl/r16_vld_dly.sv
// Fixed-latency valid delay line with asynchronous clear.
// Aligns out_valid with read data leaving memory and output path.
module r16_vld_dly #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= DEPTH'({sr, d});
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/r16_fft_seq.sv
// Phase sequencer for one radix-16 transform:
// LOAD -> COMPUTE -> DRAIN -> UNLOAD -> FLUSH, driving the AGU enables.
module r16_fft_seq
    import r16_pkg::*;
#(
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int LOAD_BEATS    = DEF_LOAD_BEATS,
    parameter int COMP_CYCLES   = DEF_COMP_CYCLES,
    parameter int DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
    parameter int UNLOAD_CYCLES = DEF_UNLOAD_CYCLES,
    parameter int OUT_LAT       = DEF_OUT_LAT
) (
    input  logic         clk,
    input  logic         rst_n,
    r16_fft_seq_if.slave bus
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t LOAD_LAST  = cnt_t'(LOAD_BEATS - 1);
    localparam cnt_t COMP_LAST  = cnt_t'(COMP_CYCLES - 1);
    localparam cnt_t DRAIN_LAST = cnt_t'(DRAIN_CYCLES - 1);
    localparam cnt_t UNLD_LAST  = cnt_t'(UNLOAD_CYCLES - 1);
    localparam cnt_t DONE_PRE   = cnt_t'(OUT_LAT - 1);
    localparam cnt_t FLUSH_LAST = cnt_t'(OUT_LAT);

    r16_state_e state;
    r16_state_e nxt;
    cnt_t       cnt;
    logic       cnt_step;
    logic       done_q;
    logic       err_q;
    logic       wrfd_q;
    logic       agu_q;
    logic       rc_q;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (bus.start) nxt = LOAD;
            LOAD:    if (bus.in_valid && cnt == LOAD_LAST) nxt = COMP;
            COMP:    if (cnt == COMP_LAST)
                         nxt = (DRAIN_CYCLES == 0) ? UNLOAD : DRAIN;
            DRAIN:   if (cnt == DRAIN_LAST) nxt = UNLOAD;
            UNLOAD:  if (cnt == UNLD_LAST) nxt = FLUSH;
            FLUSH:   if (cnt == FLUSH_LAST) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // LOAD counts accepted beats only; other busy states count cycles
    assign cnt_step = (state == LOAD) ? bus.in_valid : (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            wrfd_q <= 1'b0;
            agu_q  <= 1'b0;
            rc_q   <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                cnt <= '0;
            end else if (cnt_step) begin
                cnt <= cnt + cnt_t'(1);
            end
            done_q <= (state == FLUSH) && (cnt == DONE_PRE);
            err_q  <= bus.start && (state != IDLE);
            wrfd_q <= bus.in_valid && (state == LOAD);
            agu_q  <= (nxt == COMP) || (nxt == UNLOAD);
            rc_q   <= (nxt == UNLOAD);
        end
    end

    r16_vld_dly #(
        .DEPTH(OUT_LAT)
    ) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (agu_q && rc_q),
        .q    (bus.out_valid)
    );

    assign bus.busy      = (state != IDLE);
    assign bus.in_ready  = (state == LOAD);
    assign bus.done      = done_q;
    assign bus.start_err = err_q;
    assign bus.wrfd_en   = wrfd_q;
    assign bus.agu_en    = agu_q;
    assign bus.rc_sel    = rc_q;
    assign bus.phase     = state;

endmodule

// File: tb/tb_r16_fft_seq.sv
// Self-checking bench for r16_fft_seq: per-cycle waveform compare
// against phase windows derived from the phase lengths.
module tb_r16_fft_seq;
  import r16_pkg::*;

  localparam int T6_L   = 1;
  localparam int T6_C   = 6;
  localparam int T6_D   = 0;
  localparam int T6_U   = 1;
  localparam int T6_LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   iv [16384];

  r16_fft_seq_if bus ();
  r16_fft_seq_if bus6 ();

  r16_fft_seq u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  r16_fft_seq #(
    .CNT_WIDTH    (DEF_CNT_WIDTH),
    .LOAD_BEATS   (T6_L),
    .COMP_CYCLES  (T6_C),
    .DRAIN_CYCLES (T6_D),
    .UNLOAD_CYCLES(T6_U),
    .OUT_LAT      (T6_LAT)
  ) u_dut6 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus6)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic drive(input bit sel, input logic s, input logic v);
    if (sel) begin
      bus6.start = s;
      bus6.in_valid = v;
    end else begin
      bus.start = s;
      bus.in_valid = v;
    end
  endtask

  // {busy,done,start_err,in_ready,wrfd_en,agu_en,rc_sel,out_valid,phase}
  function automatic logic [10:0] smp(input bit sel);
    if (sel)
      return {bus6.busy, bus6.done, bus6.start_err, bus6.in_ready,
              bus6.wrfd_en, bus6.agu_en, bus6.rc_sel, bus6.out_valid,
              bus6.phase};
    return {bus.busy, bus.done, bus.start_err, bus.in_ready,
            bus.wrfd_en, bus.agu_en, bus.rc_sel, bus.out_valid,
            bus.phase};
  endfunction

  // start at cycle 0; extra starts at e1 and (optionally) the done cycle.
  // err0: a start on the previous run's done cycle flags start_err now.
  task automatic run_one(input bit sel, input bit rnd, input int e1,
                         input bit e2_done, input bit err0,
                         input int abort_at, input string tag);
    int L, C, D, U, LAT;
    int le, cs, us, dn, last, k, nw, nov, dseen, pph;
    logic pst, piv;
    int mism [9];
    int ft [9];
    int fo [9];
    int fe [9];
    int ex [9];
    string nm [9];
    logic [10:0] o;
    nm = '{"busy", "done", "start_err", "in_ready", "wrfd_en",
           "agu_en", "rc_sel", "out_valid", "phase"};
    L   = sel ? T6_L   : DEF_LOAD_BEATS;
    C   = sel ? T6_C   : DEF_COMP_CYCLES;
    D   = sel ? T6_D   : DEF_DRAIN_CYCLES;
    U   = sel ? T6_U   : DEF_UNLOAD_CYCLES;
    LAT = sel ? T6_LAT : DEF_OUT_LAT;
    for (int t = 0; t < 16384; t++)
      iv[t] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    k = 0;
    le = -1;
    for (int t = 1; t < 16384 && le < 0; t++) begin
      if (iv[t]) begin
        k++;
        if (k == L) le = t;
      end
    end
    cs = le + 1;
    us = cs + C + D;
    dn = us + U + LAT;
    last = (abort_at >= 0) ? abort_at : dn;
    nw = 0;
    nov = 0;
    dseen = -1;
    pph = 0;
    pst = 1'b0;
    piv = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mism[i] = 0;
      ft[i] = -1;
      fo[i] = 0;
      fe[i] = 0;
    end
    for (int t = 0; t <= last; t++) begin
      logic s;
      int ph;
      s = (t == 0) || (t == e1) || (e2_done && t == dn);
      drive(sel, s, iv[t]);
      ph = 0;
      if (t >= 1 && t <= le) ph = 1;
      else if (t >= cs && t < cs + C) ph = 2;
      else if (t >= cs + C && t < us) ph = 3;
      else if (t >= us && t < us + U) ph = 4;
      else if (t >= us + U && t <= dn) ph = 5;
      ex[0] = int'(ph != 0);
      ex[1] = int'(t == dn);
      ex[2] = (t == 0) ? int'(err0) : int'(pst && pph != 0);
      ex[3] = int'(ph == 1);
      ex[4] = int'(piv && pph == 1);
      ex[5] = int'(ph == 2 || ph == 4);
      ex[6] = int'(ph == 4);
      ex[7] = int'(t >= us + LAT && t < us + U + LAT);
      ex[8] = ph;
      o = smp(sel);
      for (int i = 0; i < 9; i++) begin
        int ob;
        ob = (i == 8) ? int'(o[2:0]) : int'(o[10-i]);
        if (ob != ex[i]) begin
          if (mism[i] == 0) begin
            ft[i] = t;
            fo[i] = ob;
            fe[i] = ex[i];
          end
          mism[i]++;
        end
      end
      nw += int'(o[6]);
      nov += int'(o[3]);
      if (o[9] && dseen < 0) dseen = t;
      pph = ph;
      pst = s;
      piv = iv[t];
      @(posedge clk);
      #1;
    end
    drive(sel, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      n_chk++;
      assert (mism[i] === 0) n_pass++;
      else $error("FAIL %s/%s mismatches=%0d first_cycle=%0d observed=%0d expected=%0d",
                  tag, nm[i], mism[i], ft[i], fo[i], fe[i]);
    end
    if (abort_at < 0) begin
      chk({tag, "/wrfd_count"}, nw, L);
      chk({tag, "/out_valid_count"}, nov, U);
      chk({tag, "/done_cycle"}, dseen, dn);
    end
  endtask

  initial begin
    int bad;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset/outputs", int'(smp(1'b0)), 0);
    chk("reset/outputs6", int'(smp(1'b1)), 0);
    @(negedge clk) rst_n = 1'b1;

    bad = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (smp(1'b0) != 11'd0 || smp(1'b1) != 11'd0) bad++;
    end
    chk("idle50/nonzero_cycles", bad, 0);

    run_one(1'b0, 1'b0, -1, 1'b0, 1'b0, -1, "full");
    run_one(1'b0, 1'b1, -1, 1'b0, 1'b0, -1, "gaps");
    run_one(1'b0, 1'b0, 1 + DEF_LOAD_BEATS + 100, 1'b1, 1'b0, -1, "err_a");
    run_one(1'b0, 1'b0, -1, 1'b0, 1'b1, -1, "err_b");

    run_one(1'b0, 1'b0, -1, 1'b0, 1'b0,
            1 + DEF_LOAD_BEATS + DEF_COMP_CYCLES + DEF_DRAIN_CYCLES + 100,
            "abort");
    #2 rst_n = 1'b0;
    #1;
    chk("abort/async_clear", int'(smp(1'b0)), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_one(1'b0, 1'b0, -1, 1'b0, 1'b0, -1, "rerun");

    run_one(1'b1, 1'b1, -1, 1'b0, 1'b0, -1, "nodrain_rnd");
    run_one(1'b1, 1'b0, -1, 1'b0, 1'b0, -1, "nodrain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
